// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two read ports with busy flags, a write port,
// a reservation port and the pending-reservation count.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              rsv;
    logic [ADDR_W-1:0] rsv_addr;
    logic              busy1;
    logic              busy2;
    logic [ADDR_W:0]   pend_cnt;

    modport master (
        output raddr1, raddr2, we, waddr, wdata, rsv, rsv_addr,
        input  rdata1, rdata2, busy1, busy2, pend_cnt
    );

    modport slave (
        input  raddr1, raddr2, we, waddr, wdata, rsv, rsv_addr,
        output rdata1, rdata2, busy1, busy2, pend_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with a per-register busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input logic         clk,
    input logic         rst_n,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic we_eff, rsv_eff, set_new, clr_old;

    // Register 0 is never written nor reserved when hardwired, so it stays zero.
    assign we_eff  = bus.we  && !(ZERO_REG && (bus.waddr == '0));
    assign rsv_eff = bus.rsv && !(ZERO_REG && (bus.rsv_addr == '0));

    assign set_new = rsv_eff && !busy_q[bus.rsv_addr];
    assign clr_old = we_eff && busy_q[bus.waddr] &&
                     !(rsv_eff && (bus.rsv_addr == bus.waddr));

    always_comb begin
        busy_d = busy_q;
        if (we_eff)  busy_d[bus.waddr]    = 1'b0;
        if (rsv_eff) busy_d[bus.rsv_addr] = 1'b1;
    end

    always_comb begin
        unique case ({set_new, clr_old})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (we_eff) regs_q[bus.waddr] <= bus.wdata;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    logic [ADDR_W-1:0] raddr   [2];
    logic [DATA_W-1:0] rdata   [2];
    logic              busy_rd [2];

    assign raddr[0] = bus.raddr1;
    assign raddr[1] = bus.raddr2;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rdata[i]   = regs_q[raddr[i]];
            busy_rd[i] = busy_q[raddr[i]];
            if (BYPASS && we_eff && (raddr[i] == bus.waddr)) begin
                rdata[i]   = bus.wdata;
                busy_rd[i] = 1'b0;
            end
            // Outputs are forced low throughout reset, including any bypass path.
            if (!rst_n) begin
                rdata[i]   = '0;
                busy_rd[i] = 1'b0;
            end
        end
    end

    assign bus.rdata1   = rdata[0];
    assign bus.rdata2   = rdata[1];
    assign bus.busy1    = busy_rd[0];
    assign bus.busy2    = busy_rd[1];
    assign bus.pend_cnt = cnt_q;
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 32, shall set the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, shall set the address width; depth is 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, shall hardwire register 0 to zero when 1 and make it an ordinary register when 0.
REQ-004 clk  input  1  shall be the single clock; all state shall update on the rising edge.
REQ-005 rst_n  input  1  shall be the asynchronous, active-low reset.
REQ-006 raddr1, raddr2  input  ADDR_W  shall be the read port addresses.
REQ-007 rdata1, rdata2  output  DATA_W  shall be the combinational read data for raddr1 and raddr2.
REQ-008 we  input  1  shall be the write enable.
REQ-009 waddr  input  ADDR_W  shall be the write address.
REQ-010 wdata  input  DATA_W  shall be the write data.
REQ-011 rsv  input  1  shall request a scoreboard reservation, marking a register as awaiting a pending write.
REQ-012 rsv_addr  input  ADDR_W  shall be the register to reserve.
REQ-013 busy1, busy2  output  1  shall be the combinational scoreboard busy flags for raddr1 and raddr2.
REQ-014 pend_cnt  output  ADDR_W+1  shall be the count of currently reserved registers.

Function
REQ-015 The write path shall store wdata into register waddr on the rising edge when we=1.
REQ-016 When ZERO_REG=1, a write to address 0 shall be discarded, reads of address 0 shall return 0, and busy for address 0 shall read 0.
REQ-017 The read ports shall be independent; raddr1=raddr2 shall return identical data and busy values.
REQ-018 The scoreboard shall hold one busy bit per register, all cleared at reset.
REQ-019 A clock edge with rsv=1 shall set busy[rsv_addr]; rsv to address 0 with ZERO_REG=1 shall be ignored.
REQ-020 A clock edge with we=1 shall clear busy[waddr].
REQ-021 On an edge with rsv=1, we=1 and rsv_addr=waddr, the data shall be written and the busy bit shall end set, so the reservation takes priority.
REQ-022 A reservation of an already busy register shall leave it busy and shall not change pend_cnt.
REQ-023 A write to a non-busy register shall store the data and shall not change pend_cnt.
REQ-024 pend_cnt shall equal the population count of busy bits after every edge.
REQ-025 pend_cnt shall increment by one for each newly set bit, decrement by one for each cleared bit, and be unchanged when one bit is set and another cleared on the same edge.
REQ-026 pend_cnt shall never wrap; its maximum value is 2**ADDR_W, or 2**ADDR_W-1 when ZERO_REG=1.

Reset
REQ-027 rst_n=0 shall immediately, without waiting for a clock edge, clear every register to 0, every busy bit to 0 and pend_cnt to 0.
REQ-028 While rst_n=0, rdata1, rdata2, busy1 and busy2 shall read 0, and we and rsv shall be ignored.
REQ-029 A reset asserted mid-operation shall discard all pending reservations; the first post-release edge shall behave as from power-up.

Configuration
REQ-030 With macro REG_FILE_BYPASS_EN defined, a read with we=1 and raddr=waddr (excluding address 0 when ZERO_REG=1) shall return wdata and busy=0 combinationally in the same cycle.
REQ-031 Without REG_FILE_BYPASS_EN, such a read shall return the old register contents and the old busy value, with the new value visible from the cycle after the edge.

Verification
REQ-032 Reset clear: write 0xDEADBEEF to r5, pulse rst_n low between edges -> rdata1 for r5 is 0 immediately and pend_cnt=0.
REQ-033 Zero register: we=1, waddr=0, wdata=0xFFFFFFFF, then raddr1=0 -> rdata1=0; rsv to r0 -> busy1=0 and pend_cnt=0.
REQ-034 Scoreboard: rsv r3, then rsv r7, then we r3 with 0x12 -> pend_cnt goes 1,2,1, busy for r3=0, busy for r7=1, and r3 reads 0x12.
REQ-035 Collision: r4 busy, same edge we r4=0x55 and rsv r4 -> r4 reads 0x55, r4 stays busy, pend_cnt unchanged.
REQ-036 Bypass: we=1, waddr=9, wdata=0xA5A5A5A5, raddr2=9 before the edge -> rdata2=0xA5A5A5A5 when REG_FILE_BYPASS_EN is defined, old value otherwise.
REQ-037 Saturation: reserve all registers r1..r31 with ZERO_REG=1 -> pend_cnt=31, and a further rsv to r1 leaves pend_cnt=31.
